// File: rtl/npc_dmem_bridge_pkg.sv
// rtl/npc_dmem_bridge_pkg.sv - size codes, FSM states and store lane helpers for the data-memory bridge
package npc_dmem_bridge_pkg;

  localparam logic [1:0] MEM_SZ_B   = 2'b00;
  localparam logic [1:0] MEM_SZ_H   = 2'b01;
  localparam logic [1:0] MEM_SZ_W   = 2'b10;
  localparam logic [1:0] MEM_SZ_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } bridge_state_e;

  function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      MEM_SZ_B: ok = 1'b1;
      MEM_SZ_H: ok = ~off[0];
      MEM_SZ_W: ok = (off == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      MEM_SZ_B: m = 4'b0001 << off;
      MEM_SZ_H: m = 4'b0011 << off;
      default:  m = 4'hF;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      MEM_SZ_B: r = {4{d[7:0]}};
      MEM_SZ_H: r = {2{d[15:0]}};
      default:  r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/npc_load_align.sv
// rtl/npc_load_align.sv - shifts a target word down to the addressed lane and sign/zero extends it
module npc_load_align
  import npc_dmem_bridge_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] value
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      MEM_SZ_B: value = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
      MEM_SZ_H: value = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
      default:  value = shifted;
    endcase
  end

endmodule

// File: rtl/npc_dmem_bridge.sv
// rtl/npc_dmem_bridge.sv - load/store bridge with posted writes, configurable read latency and core stall
module npc_dmem_bridge
  import npc_dmem_bridge_pkg::*;
#(
  parameter int                     NUM_TGT    = 2,
  parameter logic [NUM_TGT*32-1:0]  TGT_BASE   = {32'h1000_0000, 32'h8000_0000},
  parameter logic [NUM_TGT*32-1:0]  TGT_MASK   = {32'hF000_0000, 32'hF000_0000},
  parameter int                     RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_ren,
  input  logic                    core_wen,
  input  logic [31:0]             core_addr,
  input  logic [1:0]              core_size,
  input  logic                    core_unsigned,
  input  logic [31:0]             core_wdata,
  output logic [31:0]             core_rdata,
  output logic                    core_stall,
  output logic                    core_err,
  output logic [31:0]             bus_addr,
  output logic                    bus_ren,
  output logic                    bus_wen,
  output logic [NUM_TGT-1:0]      bus_sel,
  output logic [3:0]              bus_wmask,
  output logic [31:0]             bus_wdata,
  input  logic [NUM_TGT*32-1:0]   bus_rdata
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY);

  bridge_state_e      state, state_next;
  logic [2:0]         lat_cnt;
  logic [NUM_TGT-1:0] hit_sel;
  logic               hit;
  logic               legal;
  logic               req;
  logic [1:0]         req_off;
  logic [1:0]         req_size;
  logic               req_zext;
  logic [31:0]        sel_rdata;
  logic [31:0]        load_value;

  // Lowest-index target wins when address windows overlap.
  always_comb begin
    hit_sel = '0;
    hit     = 1'b0;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (!hit && ((core_addr & TGT_MASK[32*t +: 32]) == TGT_BASE[32*t +: 32])) begin
        hit_sel[t] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

  assign legal = hit & size_aligned(core_size, core_addr[1:0]);
  assign req   = core_ren | core_wen;

  always_comb begin
    sel_rdata = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (bus_sel[t]) sel_rdata = sel_rdata | bus_rdata[32*t +: 32];
    end
  end

  npc_load_align u_align (
    .rdata    (sel_rdata),
    .offset   (req_off),
    .size     (req_size),
    .zero_ext (req_zext),
    .value    (load_value)
  );

  always_comb begin
    state_next = state;
    core_stall = 1'b0;
    bus_ren    = 1'b0;
    bus_wen    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (core_wen) begin
          state_next = legal ? ST_WRITE : ST_IDLE;
        end else if (core_ren) begin
          core_stall = 1'b1;
          state_next = legal ? ST_READ_WAIT : ST_RESP;
        end
      end
      ST_WRITE: begin
        bus_wen    = 1'b1;
        core_stall = req;
        state_next = ST_IDLE;
      end
      ST_READ_WAIT: begin
        core_stall = 1'b1;
        bus_ren    = (lat_cnt == 3'd0);
        if (lat_cnt == LAT_LAST) state_next = ST_RESP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lat_cnt    <= 3'd0;
      bus_addr   <= '0;
      bus_sel    <= '0;
      bus_wmask  <= '0;
      bus_wdata  <= '0;
      core_rdata <= '0;
      core_err   <= 1'b0;
      req_off    <= '0;
      req_size   <= '0;
      req_zext   <= 1'b0;
    end else begin
      state    <= state_next;
      core_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          lat_cnt <= 3'd0;
          if (req) begin
            // ren&wen is executed as the store but still flagged.
            core_err <= ~legal | (core_ren & core_wen);
            if (legal) begin
              bus_addr <= {core_addr[31:2], 2'b00};
              bus_sel  <= hit_sel;
              req_off  <= core_addr[1:0];
              req_size <= core_size;
              req_zext <= core_unsigned;
            end
            if (core_wen && legal) begin
              bus_wmask <= lane_mask(core_size, core_addr[1:0]);
              bus_wdata <= lane_data(core_size, core_wdata);
            end
            if (!core_wen && !legal) core_rdata <= '0;
          end
        end
        ST_READ_WAIT: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_cnt == LAT_LAST) core_rdata <= load_value;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_dmem_bridge.sv
// tb/tb_npc_dmem_bridge.sv - four bridges at latencies 0/1/4/7 against a transaction-level timeline model
module tb_npc_dmem_bridge;

  localparam int NL   = 4;
  localparam int MAXC = 1600;
  localparam logic [63:0] TB_BASE = {32'h1000_0000, 32'h8000_0000};
  localparam logic [63:0] TB_MASK = {32'hF000_0000, 32'hF000_0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        rst [NL];
  logic        core_ren [NL], core_wen [NL], core_unsigned [NL];
  logic [31:0] core_addr [NL], core_wdata [NL], core_rdata [NL];
  logic [1:0]  core_size [NL];
  logic        core_stall [NL], core_err [NL], bus_ren [NL], bus_wen [NL];
  logic [31:0] bus_addr [NL], bus_wdata [NL];
  logic [1:0]  bus_sel [NL];
  logic [3:0]  bus_wmask [NL];
  logic [63:0] bus_rdata [NL];
  bit          fixed_mode [NL];
  logic [31:0] fixed_val [NL];

  // Expected per-cycle behaviour, filled in by the request driver ahead of time.
  bit        e_stall [NL][MAXC];
  bit        e_ren   [NL][MAXC];
  bit        e_wen   [NL][MAXC];
  bit        e_err   [NL][MAXC];
  bit        e_rdset [NL][MAXC];
  bit [31:0] e_rdval [NL][MAXC];
  bit [31:0] e_addr  [NL][MAXC];
  bit [31:0] e_wdata [NL][MAXC];
  bit [3:0]  e_mask  [NL][MAXC];
  bit [1:0]  e_sel   [NL][MAXC];
  int        wbusy   [NL];

  function automatic int lat_of(input int ln);
    return (ln == 0) ? 0 : (ln == 1) ? 1 : (ln == 2) ? 4 : 7;
  endfunction

  function automatic logic [31:0] rd_val(input bit fm, input logic [31:0] fv, input int ln, input int t, input int c);
    if (fm) return fv;
    return (32'(c) * 32'h9E37_79B1) ^ (32'(t) << 24) ^ (32'(ln) << 12) ^ 32'h5A5A_0F0F;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign bus_rdata[g] = {rd_val(fixed_mode[g], fixed_val[g], g, 1, cyc),
                           rd_val(fixed_mode[g], fixed_val[g], g, 0, cyc)};
    npc_dmem_bridge #(
      .NUM_TGT    (2),
      .TGT_BASE   (TB_BASE),
      .TGT_MASK   (TB_MASK),
      .RD_LATENCY ((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 4 : 7)
    ) u_dut (
      .clk           (clk),
      .rst           (rst[g]),
      .core_ren      (core_ren[g]),
      .core_wen      (core_wen[g]),
      .core_addr     (core_addr[g]),
      .core_size     (core_size[g]),
      .core_unsigned (core_unsigned[g]),
      .core_wdata    (core_wdata[g]),
      .core_rdata    (core_rdata[g]),
      .core_stall    (core_stall[g]),
      .core_err      (core_err[g]),
      .bus_addr      (bus_addr[g]),
      .bus_ren       (bus_ren[g]),
      .bus_wen       (bus_wen[g]),
      .bus_sel       (bus_sel[g]),
      .bus_wmask     (bus_wmask[g]),
      .bus_wdata     (bus_wdata[g]),
      .bus_rdata     (bus_rdata[g])
    );
  end

  task automatic check(input string name, input int ln, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lane%0d cyc%0d: got %h want %h", name, ln, cyc, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int t = 0; t < 2; t++)
      if ((a & TB_MASK[32*t +: 32]) == TB_BASE[32*t +: 32]) return t;
    return -1;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit aligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b0;
    return (a % nbytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] mask_model(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] m = 4'b0;
    for (int i = 0; i < nbytes(sz); i++) m[(a % 4) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] wdata_model(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] w, input logic [31:0] a, input logic [1:0] sz, input bit u);
    longint unsigned v, span;
    int nb;
    nb   = nbytes(sz);
    span = 64'd1 << (8 * nb);
    v    = {32'b0, w} >> (8 * (a % 4));
    v    = v % span;
    if (!u && nb < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // One core request: record its expected timeline, drive it, hold it until consumed.
  task automatic issue(input int ln, input bit r, input bit w, input logic [31:0] a, input logic [1:0] sz,
                       input bit u, input logic [31:0] d, output int nstall, output logic [31:0] rd, output int acc);
    int c0, s, t, fin, lat;
    bit ok, done;
    logic [31:0] val;
    c0  = cyc;
    s   = (c0 == wbusy[ln]) ? c0 + 1 : c0;
    acc = s;
    t   = decode(a);
    ok  = (t >= 0) && aligned(a, sz);
    lat = lat_of(ln);
    fin = s;
    if (w) begin
      if (ok) begin
        e_wen[ln][s+1]   = 1'b1;
        e_addr[ln][s+1]  = (a / 4) * 4;
        e_sel[ln][s+1]   = 2'(1 << t);
        e_mask[ln][s+1]  = mask_model(a, sz);
        e_wdata[ln][s+1] = wdata_model(d, sz);
        wbusy[ln]        = s + 1;
      end
      if (!ok || r) e_err[ln][s+1] = 1'b1;
    end else begin
      if (ok) begin
        fin = s + lat + 2;
        e_ren[ln][s+1]  = 1'b1;
        e_addr[ln][s+1] = (a / 4) * 4;
        e_sel[ln][s+1]  = 2'(1 << t);
        val = load_model(rd_val(fixed_mode[ln], fixed_val[ln], ln, t, s + 1 + lat), a, sz, u);
      end else begin
        fin = s + 1;
        val = 32'h0;
        e_err[ln][fin] = 1'b1;
      end
      e_rdset[ln][fin] = 1'b1;
      e_rdval[ln][fin] = val;
    end
    for (int k = c0; k < fin; k++) e_stall[ln][k] = 1'b1;
    core_ren[ln] = r; core_wen[ln] = w; core_addr[ln] = a;
    core_size[ln] = sz; core_unsigned[ln] = u; core_wdata[ln] = d;
    nstall = 0; rd = 32'h0; done = 1'b0;
    while (!done && nstall < 20) begin
      @(negedge clk);
      if (core_stall[ln] !== 1'b1) begin
        rd = core_rdata[ln];
        done = 1'b1;
      end else begin
        nstall++;
        @(posedge clk); #1;
      end
    end
    if (!done) check("consume_timeout", ln, 32'(nstall), 32'(fin - c0));
    else check("stall_len", ln, 32'(nstall), 32'(fin - c0));
    @(posedge clk); #1;
    core_ren[ln] = 1'b0; core_wen[ln] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_lane(input int ln);
    int ns, acc, c0, reg_sel;
    logic [31:0] rd, a;
    bit r, w;
    int kind;
    fixed_mode[ln] = 1'b1;
    fixed_val[ln]  = 32'h80FF_FF7F;
    if (ln == 1) begin
      issue(ln, 0, 1, 32'h8000_0010, 2'd2, 0, 32'h1234_5678, ns, rd, acc);
      check("t1_stall", ln, 32'(ns), 32'd0);
      check("t1_model_mask", ln, 32'(e_mask[ln][acc+1]), 32'hF);
      check("t1_model_sel", ln, 32'(e_sel[ln][acc+1]), 32'h1);
      check("t1_model_addr", ln, e_addr[ln][acc+1], 32'h8000_0010);
      idle(1);
      issue(ln, 1, 0, 32'h8000_0003, 2'd0, 0, 32'h0, ns, rd, acc);
      check("t2_lb_stall", ln, 32'(ns), 32'd3);
      check("t2_lb_data", ln, rd, 32'hFFFF_FF80);
      issue(ln, 1, 0, 32'h8000_0003, 2'd0, 1, 32'h0, ns, rd, acc);
      check("t2_lbu_data", ln, rd, 32'h0000_0080);
      issue(ln, 0, 1, 32'h1000_0002, 2'd1, 0, 32'h0000_ABCD, ns, rd, acc);
      check("t3_model_mask", ln, 32'(e_mask[ln][acc+1]), 32'hC);
      check("t3_model_wdata", ln, e_wdata[ln][acc+1], 32'hABCD_ABCD);
      check("t3_model_sel", ln, 32'(e_sel[ln][acc+1]), 32'h2);
      issue(ln, 1, 0, 32'h1000_0000, 2'd2, 0, 32'h0, ns, rd, acc);
      check("t3_lw_stall", ln, 32'(ns), 32'd4);
      check("t3_lw_data", ln, rd, 32'h80FF_FF7F);
      issue(ln, 0, 1, 32'h8000_0001, 2'd1, 0, 32'h5555_5555, ns, rd, acc);
      check("t4_stall", ln, 32'(ns), 32'd0);
      check("t4_model_err", ln, 32'(e_err[ln][acc+1]), 32'h1);
      issue(ln, 1, 0, 32'h0000_0000, 2'd2, 0, 32'h0, ns, rd, acc);
      check("t5_stall", ln, 32'(ns), 32'd1);
      check("t5_data", ln, rd, 32'h0);
    end else if (ln == 0 || ln == 3) begin
      issue(ln, 1, 0, 32'h8000_0003, 2'd0, 0, 32'h0, ns, rd, acc);
      check("t2_lb_stall", ln, 32'(ns), (ln == 0) ? 32'd2 : 32'd9);
      check("t2_lb_data", ln, rd, 32'hFFFF_FF80);
      issue(ln, 1, 0, 32'h8000_0003, 2'd0, 1, 32'h0, ns, rd, acc);
      check("t2_lbu_data", ln, rd, 32'h0000_0080);
    end else begin
      fixed_val[ln] = 32'hCAFE_F00D;
      issue(ln, 1, 0, 32'h8000_0040, 2'd2, 0, 32'h0, ns, rd, acc);
      check("t6_pre_data", ln, rd, 32'hCAFE_F00D);
      c0 = cyc;
      e_ren[ln][c0+1] = 1'b1; e_addr[ln][c0+1] = 32'h8000_0040; e_sel[ln][c0+1] = 2'b01;
      for (int k = c0; k < c0 + 4; k++) e_stall[ln][k] = 1'b1;
      e_rdset[ln][c0+4] = 1'b1; e_rdval[ln][c0+4] = 32'h0;
      core_ren[ln] = 1'b1; core_addr[ln] = 32'h8000_0040; core_size[ln] = 2'd2;
      idle(3);
      rst[ln] = 1'b1; core_ren[ln] = 1'b0;
      idle(1);
      rst[ln] = 1'b0;
      @(negedge clk);
      check("t6_stall", ln, 32'(core_stall[ln]), 32'h0);
      check("t6_ren", ln, 32'(bus_ren[ln]), 32'h0);
      check("t6_rdata", ln, core_rdata[ln], 32'h0);
      check("t6_sel", ln, 32'(bus_sel[ln]), 32'h0);
      idle(1);
    end
    fixed_mode[ln] = 1'b0;
    while (cyc < MAXC - 40) begin
      kind = $urandom_range(0, 99);
      r = (kind < 45) || (kind >= 85 && kind < 92) || kind >= 92;
      w = (kind >= 45 && kind < 92);
      if (kind >= 92) w = 1'b0;
      reg_sel = $urandom_range(0, 3);
      a = (reg_sel < 2) ? 32'h8000_0000 : (reg_sel == 2) ? 32'h1000_0000 : 32'h4000_0000;
      a = a | 32'($urandom_range(0, 255));
      issue(ln, r, w, a, ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), $urandom, ns, rd, acc);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  initial begin
    logic [31:0] cur [NL];
    for (int i = 0; i < NL; i++) cur[i] = 32'h0;
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < MAXC) begin
        for (int ln = 0; ln < NL; ln++) begin
          if (e_rdset[ln][cyc]) cur[ln] = e_rdval[ln][cyc];
          check("stall", ln, 32'(core_stall[ln]), 32'(e_stall[ln][cyc]));
          check("bus_ren", ln, 32'(bus_ren[ln]), 32'(e_ren[ln][cyc]));
          check("bus_wen", ln, 32'(bus_wen[ln]), 32'(e_wen[ln][cyc]));
          check("core_err", ln, 32'(core_err[ln]), 32'(e_err[ln][cyc]));
          check("core_rdata", ln, core_rdata[ln], cur[ln]);
          if (e_ren[ln][cyc] || e_wen[ln][cyc]) begin
            check("bus_addr", ln, bus_addr[ln], e_addr[ln][cyc]);
            check("bus_sel", ln, 32'(bus_sel[ln]), 32'(e_sel[ln][cyc]));
          end
          if (e_wen[ln][cyc]) begin
            check("bus_wmask", ln, 32'(bus_wmask[ln]), 32'(e_mask[ln][cyc]));
            check("bus_wdata", ln, bus_wdata[ln], e_wdata[ln][cyc]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NL; i++) begin
      rst[i] = 1'b1; core_ren[i] = 1'b0; core_wen[i] = 1'b0; core_addr[i] = 32'h0;
      core_size[i] = 2'd0; core_unsigned[i] = 1'b0; core_wdata[i] = 32'h0;
      fixed_mode[i] = 1'b0; fixed_val[i] = 32'h0; wbusy[i] = -1;
    end
    idle(3);
    for (int i = 0; i < NL; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      check("rst_stall", i, 32'(core_stall[i]), 32'h0);
      check("rst_err", i, 32'(core_err[i]), 32'h0);
      check("rst_bus_addr", i, bus_addr[i], 32'h0);
      check("rst_bus_sel", i, 32'(bus_sel[i]), 32'h0);
      check("rst_wmask", i, 32'(bus_wmask[i]), 32'h0);
      check("rst_wdata", i, bus_wdata[i], 32'h0);
      check("rst_rdata", i, core_rdata[i], 32'h0);
    end
    idle(1);
    fork
      run_lane(0);
      run_lane(1);
      run_lane(2);
      run_lane(3);
    join
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
